// File: rtl/io_regfile_param_if.sv
// io_regfile_param_if: pipeline-side write/read bus of the memory-mapped I/O register file.
interface io_regfile_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0] ctrl_writeReg;
  logic [DATA_WIDTH-1:0] data_writeReg;
  logic [ADDR_WIDTH-1:0] ctrl_readRegA;
  logic [ADDR_WIDTH-1:0] ctrl_readRegB;
  logic [DATA_WIDTH-1:0] data_readRegA;
  logic [DATA_WIDTH-1:0] data_readRegB;
  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB
  );
  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB
  );
endinterface

// File: rtl/io_regfile_param.sv
// io_regfile_param: parametrised register file with event, sample and control I/O banks.
// Define IO_REGFILE_WRITE_BYPASS_EN to forward same-cycle writes of general/control registers to the read ports.
module io_regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_EVT    = 5,
  parameter int NUM_SAMPLE = 4,
  parameter int NUM_CTRL   = 5
) (
  input  logic clock,
  input  logic ctrl_reset,
  io_regfile_param_if.slave bus,
  input  logic [NUM_EVT-1:0] evt_in,
  input  logic [NUM_SAMPLE*DATA_WIDTH-1:0] sample_in,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out
);
  localparam int NUM_REGS  = 2**ADDR_WIDTH;
  localparam int SMP_BASE  = NUM_EVT + 1;
  localparam int CTRL_BASE = SMP_BASE + NUM_SAMPLE;
  localparam logic [ADDR_WIDTH-1:0] RW_BASE = ADDR_WIDTH'(CTRL_BASE);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] view [NUM_REGS];
  logic [DATA_WIDTH-1:0] smpS1 [NUM_SAMPLE];
  logic [DATA_WIDTH-1:0] smpS2 [NUM_SAMPLE];
  logic [NUM_EVT-1:0] evtS1, evtS2, evtHist, evtSticky, evtClr;
  logic rwHit;
  // Everything above the sample bank (control + general) is plain read/write storage.
  assign rwHit = bus.ctrl_writeEnable && bus.ctrl_writeReg >= RW_BASE;
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (rwHit) regs[bus.ctrl_writeReg] <= bus.data_writeReg;
  always_comb begin
    evtClr = '0;
    for (int k = 0; k < NUM_EVT; k++)
      evtClr[k] = bus.ctrl_writeEnable && bus.ctrl_writeReg == ADDR_WIDTH'(k + 1);
  end
  // A fresh rising edge outranks a same-cycle clear so no event is lost.
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) begin
      evtS1     <= '0;
      evtS2     <= '0;
      evtHist   <= '0;
      evtSticky <= '0;
    end else begin
      evtS1     <= evt_in;
      evtS2     <= evtS1;
      evtHist   <= evtS2;
      evtSticky <= (evtSticky & ~evtClr) | (evtS2 & ~evtHist);
    end
  always_ff @(posedge clock or posedge ctrl_reset)
    if (ctrl_reset) for (int i = 0; i < NUM_SAMPLE; i++) begin
      smpS1[i] <= '0;
      smpS2[i] <= '0;
    end else for (int i = 0; i < NUM_SAMPLE; i++) begin
      smpS1[i] <= sample_in[i*DATA_WIDTH +: DATA_WIDTH];
      smpS2[i] <= smpS1[i];
    end
  always_comb begin
    view = regs;
    view[0] = '0;
    for (int k = 0; k < NUM_EVT; k++) view[k+1] = DATA_WIDTH'({evtS2[k], evtSticky[k]});
    for (int i = 0; i < NUM_SAMPLE; i++) view[SMP_BASE+i] = smpS2[i];
  end
`ifdef IO_REGFILE_WRITE_BYPASS_EN
  assign bus.data_readRegA = rwHit && bus.ctrl_readRegA == bus.ctrl_writeReg ? bus.data_writeReg : view[bus.ctrl_readRegA];
  assign bus.data_readRegB = rwHit && bus.ctrl_readRegB == bus.ctrl_writeReg ? bus.data_writeReg : view[bus.ctrl_readRegB];
`else
  assign bus.data_readRegA = view[bus.ctrl_readRegA];
  assign bus.data_readRegB = view[bus.ctrl_readRegB];
`endif
  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < NUM_CTRL; i++) ctrl_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[CTRL_BASE+i];
  end
endmodule

// File: tb/tb_io_regfile_param.sv
// tb_io_regfile_param: directed + randomized checks of io_regfile_param against a delay-line reference model.
module tb_io_regfile_param;
`ifdef IO_REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 1'b0;
  logic ctrl_reset = 1'b1;
  logic [4:0] evt_in = '0;
  logic [127:0] sample_in = '0;
  logic [159:0] ctrl_out;
  int total = 0;
  int passCnt = 0;
  int failCnt = 0;
  logic [31:0] mMem [32];
  logic [31:0] mSmp1 [4];
  logic [31:0] mSmp2 [4];
  logic [4:0] mD1, mD2, mD3, mSticky;
  io_regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
  io_regfile_param dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .bus(bus.slave),
    .evt_in(evt_in), .sample_in(sample_in), .ctrl_out(ctrl_out)
  );
  always #5 clock = ~clock;
  task automatic modelReset();
    for (int i = 0; i < 32; i++) mMem[i] = '0;
    for (int i = 0; i < 4; i++) begin
      mSmp1[i] = '0;
      mSmp2[i] = '0;
    end
    {mD1, mD2, mD3, mSticky} = '0;
  endtask
  function automatic logic [31:0] mRead(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (a <= 5) return {30'b0, mD2[a-1], mSticky[a-1]};
    if (a <= 9) return mSmp2[a-6];
    if (BYP && bus.ctrl_writeEnable && bus.ctrl_writeReg == a) return bus.data_writeReg;
    return mMem[a];
  endfunction
  task automatic tick();
    if (ctrl_reset) modelReset();
    else begin
      if (bus.ctrl_writeEnable && bus.ctrl_writeReg >= 10) mMem[bus.ctrl_writeReg] = bus.data_writeReg;
      for (int k = 0; k < 5; k++)
        mSticky[k] = (mD2[k] && !mD3[k]) || (mSticky[k] && !(bus.ctrl_writeEnable && bus.ctrl_writeReg == 5'(k + 1)));
      mD3 = mD2;
      mD2 = mD1;
      mD1 = evt_in;
      for (int i = 0; i < 4; i++) begin
        mSmp2[i] = mSmp1[i];
        mSmp1[i] = sample_in[i*32 +: 32];
      end
    end
    @(posedge clock);
    #1;
  endtask
  task automatic setIn(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bus.ctrl_writeEnable = we;
    bus.ctrl_writeReg = wa;
    bus.data_writeReg = wd;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic checkAll();
    chk("rand_rdA", bus.data_readRegA, mRead(bus.ctrl_readRegA));
    chk("rand_rdB", bus.data_readRegB, mRead(bus.ctrl_readRegB));
    for (int i = 0; i < 5; i++) chk("rand_ctrl_out", ctrl_out[i*32 +: 32], mMem[10+i]);
  endtask
  initial begin
    modelReset();
    setIn(1'b0, 5'd0, 32'h0);
    bus.ctrl_readRegA = '0;
    bus.ctrl_readRegB = '0;
    #12;
    for (int a = 0; a < 32; a++) begin
      bus.ctrl_readRegA = 5'(a);
      bus.ctrl_readRegB = 5'(31 - a);
      #1;
      chk("reset_rdA", bus.data_readRegA, 32'h0);
      chk("reset_rdB", bus.data_readRegB, 32'h0);
    end
    chk("reset_ctrl_out", ctrl_out[31:0], 32'h0);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) begin
      bus.ctrl_readRegA = 5'(a);
      bus.ctrl_readRegB = 5'(31 - a);
      #1;
      chk("post_reset_rdA", bus.data_readRegA, 32'h0);
      chk("post_reset_rdB", bus.data_readRegB, 32'h0);
    end
    setIn(1'b1, 5'd0, 32'h0000_00FF);
    tick();
    setIn(1'b0, 5'd0, 32'h0);
    bus.ctrl_readRegA = 5'd0;
    #1;
    chk("addr0_write_ignored", bus.data_readRegA, 32'h0);
    setIn(1'b1, 5'd25, 32'hDEAD_BEEF);
    tick();
    setIn(1'b0, 5'd0, 32'h0);
    bus.ctrl_readRegA = 5'd25;
    bus.ctrl_readRegB = 5'd25;
    #1;
    chk("reg25_rdA", bus.data_readRegA, 32'hDEAD_BEEF);
    chk("reg25_rdB", bus.data_readRegB, 32'hDEAD_BEEF);
    setIn(1'b1, 5'd10, 32'h0000_0040);
    bus.ctrl_readRegA = 5'd10;
    #1;
    chk("ctrl_same_cycle_read", bus.data_readRegA, BYP ? 32'h40 : 32'h0);
    tick();
    setIn(1'b0, 5'd0, 32'h0);
    chk("ctrl_out0", ctrl_out[31:0], 32'h40);
    chk("ctrl_readback", bus.data_readRegA, 32'h40);
    bus.ctrl_readRegA = 5'd1;
    evt_in[0] = 1'b1;
    tick();
    chk("evt_edgeN", bus.data_readRegA, 32'h0);
    tick();
    chk("evt_level", bus.data_readRegA, 32'h2);
    tick();
    chk("evt_sticky", bus.data_readRegA, 32'h3);
    evt_in[0] = 1'b0;
    tick();
    tick();
    chk("evt_sticky_held", bus.data_readRegA, 32'h1);
    setIn(1'b1, 5'd1, 32'hFFFF_FFFF);
    tick();
    setIn(1'b0, 5'd0, 32'h0);
    chk("evt_write_clear", bus.data_readRegA, 32'h0);
    bus.ctrl_readRegA = 5'd3;
    evt_in[2] = 1'b1;
    tick();
    tick();
    setIn(1'b1, 5'd3, 32'hFFFF_FFFF);
    tick();
    setIn(1'b0, 5'd0, 32'h0);
    chk("evt_set_beats_clear", bus.data_readRegA, 32'h3);
    bus.ctrl_readRegA = 5'd6;
    sample_in[31:0] = 32'h0000_0123;
    tick();
    chk("sample_one_edge", bus.data_readRegA, 32'h0);
    tick();
    chk("sample_two_edges", bus.data_readRegA, 32'h123);
    setIn(1'b1, 5'd6, 32'h5);
    tick();
    setIn(1'b0, 5'd0, 32'h0);
    chk("sample_write_ignored", bus.data_readRegA, 32'h123);
    setIn(1'b1, 5'd25, 32'h1234_5678);
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    setIn(1'b0, 5'd0, 32'h0);
    bus.ctrl_readRegA = 5'd25;
    bus.ctrl_readRegB = 5'd3;
    #1;
    chk("reset_mid_write", bus.data_readRegA, 32'h0);
    chk("reset_clears_evt", bus.data_readRegB, 32'h0);
    tick();
    chk("high_at_release_e1", bus.data_readRegB, 32'h0);
    tick();
    chk("high_at_release_e2", bus.data_readRegB, 32'h2);
    tick();
    chk("high_at_release_e3", bus.data_readRegB, 32'h3);
    for (int c = 0; c < 400; c++) begin
      setIn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      bus.ctrl_readRegA = ($urandom_range(0, 2) == 0) ? bus.ctrl_writeReg : 5'($urandom_range(0, 31));
      bus.ctrl_readRegB = ($urandom_range(0, 2) == 0) ? bus.ctrl_writeReg : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) evt_in = 5'($urandom);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) sample_in[i*32 +: 32] = $urandom;
      #1;
      checkAll();
      tick();
    end
    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end
endmodule

// File: doc/io_regfile_param.md
Name: io_regfile_param

Overview:
- Parametrised successor to the processor's 32-entry register file with memory-mapped I/O.
- Generalises width, depth and the I/O register map:
  - a contiguous bank of event registers (buttons), with synchronised, sticky edge capture and write-to-clear;
  - a bank of synchronised sample registers (switches, position counters);
  - a bank of control registers exported to peripherals (motor speed/direction, servo).
- Sits between the pipeline's decode/writeback stages and the board I/O.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH.
- NUM_EVT, 5, event registers at addresses 1..NUM_EVT.
- NUM_SAMPLE, 4, sample registers at EVT_TOP+1..EVT_TOP+NUM_SAMPLE, where EVT_TOP = NUM_EVT.
- NUM_CTRL, 5, control registers immediately following the sample bank.
- Legal configuration requires 1+NUM_EVT+NUM_SAMPLE+NUM_CTRL <= NUM_REGS.

Ports:
- clock  in  1  single clock, all state on rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- ctrl_writeEnable  in  1  write strobe.
- ctrl_writeReg  in  ADDR_WIDTH  write address.
- data_writeReg  in  DATA_WIDTH  write data.
- ctrl_readRegA  in  ADDR_WIDTH  read address, port A.
- ctrl_readRegB  in  ADDR_WIDTH  read address, port B.
- data_readRegA  out  DATA_WIDTH  read data, port A.
- data_readRegB  out  DATA_WIDTH  read data, port B.
- evt_in  in  NUM_EVT  raw asynchronous event inputs; bit i maps to register 1+i.
- sample_in  in  NUM_SAMPLE*DATA_WIDTH  raw sample buses; slice i maps to sample register i.
- ctrl_out  out  NUM_CTRL*DATA_WIDTH  control register contents; slice i = control register i.

Behaviour:
- Reset (async assert, sync release):
  - all registers, synchroniser flops and edge-history flops clear to 0;
  - ctrl_out = 0; read ports return 0 for every address.
- Reads:
  - combinational from current register state; zero-cycle latency;
  - both ports are independent and may address the same register.
- Address 0 always reads 0; writes to it are ignored.
- Event register k (evt_in[k-1]):
  - Synchroniser: evt_in → s1 → s2 on successive edges; h = s2 delayed one cycle.
  - Read value: bit1 = s2 (live level), bit0 = sticky flag, other bits 0.
  - Sticky sets on the edge where s2=1 and h=0.
  - Raw rise before edge N → level visible after edge N+1 → sticky visible after edge N+2.
  - A write to k clears sticky at the next edge; write data is ignored.
  - Simultaneous set condition and write: set wins (sticky=1); the event is not lost.
  - Input already high when reset releases: counts as a rising edge, so sticky sets 3 edges later.
  - Pulses shorter than one clock period may be missed; this is legal.
- Sample register i:
  - two-flop synchronised copy of sample_in slice i, loaded every cycle;
  - visible 2 edges after the input changes; writes ignored;
  - multi-bit inputs must be quasi-static or Gray-coded; tearing is not corrected.
- Control register i:
  - ordinary read/write register; written on the rising edge when ctrl_writeEnable and address match;
  - ctrl_out slice i is driven directly from the flop, so a new value appears the cycle after the write.
- General registers (all remaining addresses): ordinary read/write, retain value until written or reset.
- Reset mid-write: reset dominates; the register stays 0.
- Write address decode uses the full ADDR_WIDTH; no aliasing.

Optional Feature:
- Macro: IO_REGFILE_WRITE_BYPASS_EN.
- Defined:
  - if ctrl_writeEnable=1 and the read address equals ctrl_writeReg, and the address is a general or control register, the port returns data_writeReg in the same cycle;
  - no bypass for address 0, event registers or sample registers.
- Undefined: reads return the pre-write value until the next edge.

Test Plan:
- Reset, then read all 32 addresses on both ports → 0.
- Write 0x0000_00FF to address 0, then read → 0.
- Write 0xDEAD_BEEF to reg 25; read A=25, B=25 next cycle → both 0xDEAD_BEEF.
- evt_in[0] rises before edge N:
  - reg1 reads 0x2 after edge N+1 and 0x3 after edge N+2;
  - drop evt_in → 0x1 stays;
  - write reg1 → 0x0 after the next edge.
- Hold evt_in[2] low→high timed so the sticky-set edge coincides with a write to reg3 → reg3 bit0 = 1 afterwards.
- sample_in slice 0 = 0x0000_0123:
  - reg6 reads 0x123 after 2 edges;
  - writing 0x5 to reg6 has no effect.
- Write 0x0000_0040 to control register 0 (reg10) → ctrl_out[31:0] = 0x40 after the edge.
- Bypass build, same cycle as that write, read A=10 → 0x40.
- Non-bypass build, same cycle as that write, read A=10 → old value 0.
